// File: rtl/cache_axi_arbiter_if.sv
// Cache-side read/write ports and the single AXI master port of the core.
// The arbiter takes the master view; caches and interconnect take the slave view.
interface cache_axi_arbiter_if;
   logic [31:0] i_araddr;
   logic [7:0]  i_arlen;
   logic        i_arvalid;
   logic        i_arready;
   logic [31:0] i_rdata;
   logic        i_rvalid;
   logic        i_rlast;
   logic        i_rready;

   logic [31:0] d_araddr;
   logic [7:0]  d_arlen;
   logic        d_arvalid;
   logic        d_arready;
   logic [31:0] d_rdata;
   logic        d_rvalid;
   logic        d_rlast;
   logic        d_rready;

   logic [31:0] d_awaddr;
   logic [7:0]  d_awlen;
   logic [2:0]  d_awsize;
   logic        d_awvalid;
   logic        d_awready;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_wlast;
   logic        d_wvalid;
   logic        d_wready;
   logic        d_bvalid;
   logic        d_bready;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      input  i_araddr, i_arlen, i_arvalid, i_rready,
      input  d_araddr, d_arlen, d_arvalid, d_rready,
      input  d_awaddr, d_awlen, d_awsize, d_awvalid,
      input  d_wdata, d_wstrb, d_wlast, d_wvalid, d_bready,
      input  arready, rid, rdata, rresp, rlast, rvalid,
      input  awready, wready, bid, bresp, bvalid,
      output i_arready, i_rdata, i_rvalid, i_rlast,
      output d_arready, d_rdata, d_rvalid, d_rlast,
      output d_awready, d_wready, d_bvalid,
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wid, wdata, wstrb, wlast, wvalid, bready
   );

   modport slave (
      output i_araddr, i_arlen, i_arvalid, i_rready,
      output d_araddr, d_arlen, d_arvalid, d_rready,
      output d_awaddr, d_awlen, d_awsize, d_awvalid,
      output d_wdata, d_wstrb, d_wlast, d_wvalid, d_bready,
      output arready, rid, rdata, rresp, rlast, rvalid,
      output awready, wready, bid, bresp, bvalid,
      input  i_arready, i_rdata, i_rvalid, i_rlast,
      input  d_arready, d_rdata, d_rvalid, d_rlast,
      input  d_awready, d_wready, d_bvalid,
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wid, wdata, wstrb, wlast, wvalid, bready
   );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Merges i_cache and d_cache onto one AXI master: burst-locked read grant,
// d_cache write pass-through, d_cache reads held behind in-flight writes.
module cache_axi_arbiter #(
   parameter logic [3:0] ID_I = 4'd0,
   parameter logic [3:0] ID_D = 4'd1
) (
   input logic               clk,
   input logic               rst,
   cache_axi_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rstate_e;

   rstate_e state_q;
   logic    grant_q;
   logic    wr_busy_q;
   logic    wr_busy_d;
   logic    b_hs;
   logic    d_rd_ok;
   logic    in_addr;
   logic    in_data;
   logic    ar_v;
   logic    r_rdy;
   logic    unused_resp;

   assign b_hs      = bus.bvalid & bus.d_bready;
   assign wr_busy_d = (wr_busy_q & ~b_hs) | bus.d_awvalid;
   // a dirty eviction must reach memory before the refill read
   assign d_rd_ok   = bus.d_arvalid & ~wr_busy_q & ~bus.d_awvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= R_IDLE;
         grant_q   <= 1'b0;
         wr_busy_q <= 1'b0;
      end else begin
         wr_busy_q <= wr_busy_d;
         unique case (state_q)
            R_IDLE: begin
               if (d_rd_ok) begin
                  grant_q <= 1'b1;
                  state_q <= R_ADDR;
               end else if (bus.i_arvalid) begin
                  grant_q <= 1'b0;
                  state_q <= R_ADDR;
               end
            end
            R_ADDR: begin
               if (ar_v && bus.arready)
                  state_q <= R_DATA;
            end
            R_DATA: begin
               if (bus.rvalid && r_rdy && bus.rlast)
                  state_q <= R_IDLE;
            end
            default: state_q <= R_IDLE;
         endcase
      end
   end

   assign in_addr = (state_q == R_ADDR);
   assign in_data = (state_q == R_DATA);
   assign ar_v    = in_addr & (grant_q ? bus.d_arvalid : bus.i_arvalid);
   assign r_rdy   = in_data & (grant_q ? bus.d_rready : bus.i_rready);

   assign bus.arvalid   = ar_v;
   assign bus.arid      = grant_q ? ID_D : ID_I;
   assign bus.araddr    = grant_q ? bus.d_araddr : bus.i_araddr;
   assign bus.arlen     = grant_q ? bus.d_arlen : bus.i_arlen;
   assign bus.arsize    = 3'b010;
   assign bus.arburst   = 2'b01;
   assign bus.i_arready = in_addr & ~grant_q & bus.arready;
   assign bus.d_arready = in_addr & grant_q & bus.arready;

   assign bus.rready    = r_rdy;
   assign bus.i_rdata   = bus.rdata;
   assign bus.d_rdata   = bus.rdata;
   assign bus.i_rlast   = bus.rlast;
   assign bus.d_rlast   = bus.rlast;
   assign bus.i_rvalid  = in_data & ~grant_q & bus.rvalid;
   assign bus.d_rvalid  = in_data & grant_q & bus.rvalid;

   assign bus.awid      = ID_D;
   assign bus.awaddr    = bus.d_awaddr;
   assign bus.awlen     = bus.d_awlen;
   assign bus.awsize    = bus.d_awsize;
   assign bus.awburst   = 2'b01;
   assign bus.awvalid   = bus.d_awvalid;
   assign bus.d_awready = bus.awready;
   assign bus.wid       = ID_D;
   assign bus.wdata     = bus.d_wdata;
   assign bus.wstrb     = bus.d_wstrb;
   assign bus.wlast     = bus.d_wlast;
   assign bus.wvalid    = bus.d_wvalid;
   assign bus.d_wready  = bus.wready;
   assign bus.d_bvalid  = bus.bvalid;
   assign bus.bready    = bus.d_bready;

   // responses arrive in order with a single read outstanding
   assign unused_resp = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};
endmodule
